// File: rtl/vga_pkg.sv
// Shared VGA constants and helpers for the sprite compositor.
package vga_pkg;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned COLOR_W_DEF  = 3;

  typedef enum logic {
    MIX_OR       = 1'b0,
    MIX_PRIORITY = 1'b1
  } mix_mode_e;

  // Low bit of element idx inside a packed per-sprite bus of elements width bits wide.
  function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned width);
    return idx * width;
  endfunction

endpackage

// File: rtl/vga_sprite_hit.sv
// Combinational rectangle hit test for one sprite against the current pixel.
module vga_sprite_hit #(
  parameter int unsigned COORD_W = 10
) (
  input  logic               i_en,
  input  logic [COORD_W-1:0] i_x,
  input  logic [COORD_W-1:0] i_y,
  input  logic [COORD_W-1:0] i_sx,
  input  logic [COORD_W-1:0] i_sy,
  input  logic [COORD_W-1:0] i_w,
  input  logic [COORD_W-1:0] i_h,
  output logic               o_hit
);

  logic [COORD_W:0] x_end;
  logic [COORD_W:0] y_end;
  logic             x_in;
  logic             y_in;

  // One extra bit keeps sx+w from wrapping back onto low columns; w=0 gives an empty range.
  always_comb begin
    x_end = {1'b0, i_sx} + {1'b0, i_w};
    y_end = {1'b0, i_sy} + {1'b0, i_h};
    x_in  = (i_x >= i_sx) && ({1'b0, i_x} < x_end);
    y_in  = (i_y >= i_sy) && ({1'b0, i_y} < y_end);
    o_hit = i_en && x_in && y_in;
  end

endmodule

// File: rtl/vga_sprite_mixer.sv
// N-channel sprite compositor: frame-shadowed sprite geometry, priority/OR mix, collision flags.
module vga_sprite_mixer
  import vga_pkg::*;
#(
  parameter int unsigned NUM_SPRITES = 4,
  parameter int unsigned COORD_W     = 10,
  parameter int unsigned COLOR_W     = COLOR_W_DEF,
  parameter int unsigned MIX_MODE    = 1,
  parameter int unsigned H_ACTIVE    = H_ACTIVE_DEF,
  parameter int unsigned V_ACTIVE    = V_ACTIVE_DEF,
  parameter logic [3*COLOR_W-1:0] BG_COLOR = '0
) (
  input  logic                               i_CLK,
  input  logic                               i_RST_n,
  input  logic                               i_hSync,
  input  logic                               i_vSync,
  input  logic [COORD_W-1:0]                 i_x_pos,
  input  logic [COORD_W-1:0]                 i_y_pos,
  input  logic [NUM_SPRITES-1:0]             i_spr_en,
  input  logic [NUM_SPRITES*COORD_W-1:0]     i_spr_x,
  input  logic [NUM_SPRITES*COORD_W-1:0]     i_spr_y,
  input  logic [NUM_SPRITES*COORD_W-1:0]     i_spr_w,
  input  logic [NUM_SPRITES*COORD_W-1:0]     i_spr_h,
  input  logic [NUM_SPRITES*3*COLOR_W-1:0]   i_spr_color,
  output logic [COLOR_W-1:0]                 o_red,
  output logic [COLOR_W-1:0]                 o_green,
  output logic [COLOR_W-1:0]                 o_blue,
  output logic                               o_hSync,
  output logic                               o_vSync,
  output logic [NUM_SPRITES-1:0]             o_collide,
  output logic                               o_frame
);

  localparam int unsigned PIX_W = 3 * COLOR_W;
  localparam int unsigned GEO_W = NUM_SPRITES * COORD_W;
  localparam int unsigned COL_W = NUM_SPRITES * PIX_W;
  localparam logic [COORD_W:0] H_LIM = (COORD_W+1)'(H_ACTIVE);
  localparam logic [COORD_W:0] V_LIM = (COORD_W+1)'(V_ACTIVE);
  localparam mix_mode_e MODE = (MIX_MODE == 0) ? MIX_OR : MIX_PRIORITY;

  logic [NUM_SPRITES-1:0] sh_en_q, sh_en_d;
  logic [GEO_W-1:0]       sh_x_q, sh_x_d, sh_y_q, sh_y_d, sh_w_q, sh_w_d, sh_h_q, sh_h_d;
  logic [COL_W-1:0]       sh_col_q, sh_col_d;

  logic                   vs_prev_q, vs_prev_d;
  logic [NUM_SPRITES-1:0] hit_q, hit_d;
  logic                   vis_q, vis_d;
  logic                   hs1_q, hs1_d, vs1_q, vs1_d;
  logic                   hs2_q, hs2_d, vs2_q, vs2_d;
  logic [NUM_SPRITES-1:0] acc_q, acc_d;
  logic [NUM_SPRITES-1:0] collide_q, collide_d;
  logic                   frame_q, frame_d;
  logic [PIX_W-1:0]       color_q, color_d;

  logic [NUM_SPRITES-1:0] hit;
  logic                   frame_edge;
  logic                   visible;
  logic                   multi_hit;
  logic [PIX_W-1:0]       mix;
  logic                   found;

  for (genvar k = 0; k < NUM_SPRITES; k++) begin : g_hit
    vga_sprite_hit #(
      .COORD_W(COORD_W)
    ) u_hit (
      .i_en (sh_en_q[k]),
      .i_x  (i_x_pos),
      .i_y  (i_y_pos),
      .i_sx (sh_x_q[slice_lo(k, COORD_W) +: COORD_W]),
      .i_sy (sh_y_q[slice_lo(k, COORD_W) +: COORD_W]),
      .i_w  (sh_w_q[slice_lo(k, COORD_W) +: COORD_W]),
      .i_h  (sh_h_q[slice_lo(k, COORD_W) +: COORD_W]),
      .o_hit(hit[k])
    );
  end

  // Shadow load and frame-edge detect
  always_comb begin
    frame_edge = ~i_vSync & vs_prev_q;
    sh_en_d    = sh_en_q;
    sh_x_d     = sh_x_q;
    sh_y_d     = sh_y_q;
    sh_w_d     = sh_w_q;
    sh_h_d     = sh_h_q;
    sh_col_d   = sh_col_q;
    if (frame_edge) begin
      sh_en_d  = i_spr_en;
      sh_x_d   = i_spr_x;
      sh_y_d   = i_spr_y;
      sh_w_d   = i_spr_w;
      sh_h_d   = i_spr_h;
      sh_col_d = i_spr_color;
    end
  end

  // Stage 1: hit vector, visibility, syncs, collision accumulation
  always_comb begin
    visible   = ({1'b0, i_x_pos} < H_LIM) && ({1'b0, i_y_pos} < V_LIM);
    multi_hit = |(hit & (hit - NUM_SPRITES'(1)));
    hit_d     = hit;
    vis_d     = visible;
    hs1_d     = i_hSync;
    vs1_d     = i_vSync;
    vs_prev_d = i_vSync;
    acc_d     = acc_q;
    if (visible && multi_hit) begin
      acc_d = acc_q | hit;
    end
    if (frame_edge) begin
      acc_d = '0;
    end
    collide_d = frame_edge ? acc_q : collide_q;
    frame_d   = frame_edge;
  end

  // Stage 2: colour mix and sync delay
  always_comb begin
    mix   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < NUM_SPRITES; k++) begin
      if (hit_q[k]) begin
        if (MODE == MIX_OR) begin
          mix = mix | sh_col_q[slice_lo(k, PIX_W) +: PIX_W];
        end else if (!found) begin
          mix   = sh_col_q[slice_lo(k, PIX_W) +: PIX_W];
          found = 1'b1;
        end
      end
    end
    if (hit_q == '0) begin
      mix = BG_COLOR;
    end
    color_d = vis_q ? mix : '0;
    hs2_d   = hs1_q;
    vs2_d   = vs1_q;
  end

  always_ff @(posedge i_CLK) begin
    if (!i_RST_n) begin
      sh_en_q   <= '0;
      sh_x_q    <= '0;
      sh_y_q    <= '0;
      sh_w_q    <= '0;
      sh_h_q    <= '0;
      sh_col_q  <= '0;
      vs_prev_q <= 1'b1;
      hit_q     <= '0;
      vis_q     <= 1'b0;
      hs1_q     <= 1'b1;
      vs1_q     <= 1'b1;
      hs2_q     <= 1'b1;
      vs2_q     <= 1'b1;
      acc_q     <= '0;
      collide_q <= '0;
      frame_q   <= 1'b0;
      color_q   <= '0;
    end else begin
      sh_en_q   <= sh_en_d;
      sh_x_q    <= sh_x_d;
      sh_y_q    <= sh_y_d;
      sh_w_q    <= sh_w_d;
      sh_h_q    <= sh_h_d;
      sh_col_q  <= sh_col_d;
      vs_prev_q <= vs_prev_d;
      hit_q     <= hit_d;
      vis_q     <= vis_d;
      hs1_q     <= hs1_d;
      vs1_q     <= vs1_d;
      hs2_q     <= hs2_d;
      vs2_q     <= vs2_d;
      acc_q     <= acc_d;
      collide_q <= collide_d;
      frame_q   <= frame_d;
      color_q   <= color_d;
    end
  end

  assign o_red     = color_q[PIX_W-1 -: COLOR_W];
  assign o_green   = color_q[2*COLOR_W-1 -: COLOR_W];
  assign o_blue    = color_q[COLOR_W-1:0];
  assign o_hSync   = hs2_q;
  assign o_vSync   = vs2_q;
  assign o_collide = collide_q;
  assign o_frame   = frame_q;

endmodule

// File: tb/tb_vga_sprite_mixer.sv
// Directed bench for vga_sprite_mixer: one priority-mix and one OR-mix instance on shared inputs.
module tb_vga_sprite_mixer;

  logic        clk;
  logic        rst_n;
  logic        hs, vs;
  logic [9:0]  x, y;
  logic [3:0]  spr_en;
  logic [39:0] spr_x, spr_y, spr_w, spr_h;
  logic [35:0] spr_col;

  logic [2:0]  p_r, p_g, p_b, o_r, o_g, o_b;
  logic        p_hs, p_vs, o_hs, o_vs, p_fr, o_fr;
  logic [3:0]  p_col, o_col;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         g;
    logic [9:0] x;
    logic [9:0] y;
    logic [8:0] pri;
    logic [8:0] orc;
  } vec_t;

  vec_t tbl[48];
  int   ntbl = 0;

  vga_sprite_mixer #(
    .MIX_MODE(1),
    .BG_COLOR(9'o012)
  ) dut (
    .i_CLK(clk), .i_RST_n(rst_n), .i_hSync(hs), .i_vSync(vs),
    .i_x_pos(x), .i_y_pos(y), .i_spr_en(spr_en),
    .i_spr_x(spr_x), .i_spr_y(spr_y), .i_spr_w(spr_w), .i_spr_h(spr_h),
    .i_spr_color(spr_col),
    .o_red(p_r), .o_green(p_g), .o_blue(p_b),
    .o_hSync(p_hs), .o_vSync(p_vs), .o_collide(p_col), .o_frame(p_fr)
  );

  vga_sprite_mixer #(
    .MIX_MODE(0),
    .BG_COLOR(9'o012)
  ) dut_or (
    .i_CLK(clk), .i_RST_n(rst_n), .i_hSync(hs), .i_vSync(vs),
    .i_x_pos(x), .i_y_pos(y), .i_spr_en(spr_en),
    .i_spr_x(spr_x), .i_spr_y(spr_y), .i_spr_w(spr_w), .i_spr_h(spr_h),
    .i_spr_color(spr_col),
    .o_red(o_r), .o_green(o_g), .o_blue(o_b),
    .o_hSync(o_hs), .o_vSync(o_vs), .o_collide(o_col), .o_frame(o_fr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input int g, input logic [9:0] vx, input logic [9:0] vy,
                     input logic [8:0] pri, input logic [8:0] orc);
    tbl[ntbl].g   = g;
    tbl[ntbl].x   = vx;
    tbl[ntbl].y   = vy;
    tbl[ntbl].pri = pri;
    tbl[ntbl].orc = orc;
    ntbl++;
  endtask

  task automatic set_spr(input int k, input logic en, input logic [9:0] sx, input logic [9:0] sy,
                         input logic [9:0] w, input logic [9:0] h, input logic [8:0] c);
    spr_en[k]          = en;
    spr_x[k*10 +: 10]  = sx;
    spr_y[k*10 +: 10]  = sy;
    spr_w[k*10 +: 10]  = w;
    spr_h[k*10 +: 10]  = h;
    spr_col[k*9 +: 9]  = c;
  endtask

  task automatic clear_spr();
    for (int k = 0; k < 4; k++) set_spr(k, 1'b0, '0, '0, '0, '0, '0);
  endtask

  task automatic apply(input int g);
    for (int i = 0; i < ntbl; i++) begin
      if (tbl[i].g == g) begin
        x = tbl[i].x;
        y = tbl[i].y;
        repeat (2) @(posedge clk);
        #1;
        chk($sformatf("g%0d pri (%0d,%0d)", g, tbl[i].x, tbl[i].y), {p_r, p_g, p_b}, tbl[i].pri);
        chk($sformatf("g%0d or (%0d,%0d)", g, tbl[i].x, tbl[i].y), {o_r, o_g, o_b}, tbl[i].orc);
      end
    end
  endtask

  // Drives a one-cycle vsync low with an off-screen pixel and checks the collision report.
  task automatic frame_edge(input logic [3:0] exp_col);
    x  = 10'd700;
    y  = 10'd500;
    vs = 1'b0;
    @(posedge clk);
    #1;
    chk("frame pulse pri", p_fr, 1'b1);
    chk("frame pulse or", o_fr, 1'b1);
    chk("collide pri", p_col, exp_col);
    chk("collide or", o_col, exp_col);
    vs = 1'b1;
    @(posedge clk);
    #1;
    chk("frame end pri", p_fr, 1'b0);
    chk("frame end or", o_fr, 1'b0);
  endtask

  logic h_hist[$];
  logic v_hist[$];

  initial begin
    add(0,  15, 120, 9'o012, 9'o012);
    add(1,  10, 100, 9'o707, 9'o707);
    add(1,  19, 179, 9'o707, 9'o707);
    add(1,  20, 100, 9'o012, 9'o012);
    add(1,  10, 180, 9'o012, 9'o012);
    add(1,   9, 100, 9'o012, 9'o012);
    add(1, 700, 100, 9'o000, 9'o000);
    add(1,  15, 480, 9'o000, 9'o000);
    add(2, 300, 200, 9'o700, 9'o707);
    add(2, 339, 239, 9'o700, 9'o707);
    add(2, 340, 239, 9'o012, 9'o012);
    add(2, 320, 199, 9'o012, 9'o012);
    add(3, 104,  54, 9'o070, 9'o077);
    add(3, 103,  53, 9'o070, 9'o070);
    add(3, 108,  58, 9'o007, 9'o007);
    add(3, 401, 301, 9'o770, 9'o770);
    add(3, 402, 300, 9'o012, 9'o012);
    add(4, 104,  54, 9'o070, 9'o070);
    add(4, 200,  54, 9'o007, 9'o007);
    add(4, 401, 301, 9'o770, 9'o770);
    add(5,  10, 100, 9'o707, 9'o707);
    add(5, 200, 100, 9'o012, 9'o012);
    add(6, 200, 100, 9'o707, 9'o707);
    add(6,  10, 100, 9'o012, 9'o012);
    add(7, 630,   0, 9'o707, 9'o707);
    add(7, 639,   9, 9'o707, 9'o707);
    add(7, 629,   0, 9'o012, 9'o012);
    add(7, 640,   0, 9'o000, 9'o000);
    add(7,   0,   0, 9'o012, 9'o012);
    add(7,   5,   5, 9'o012, 9'o012);
    add(7, 639,  10, 9'o012, 9'o012);

    rst_n = 1'b0;
    hs = 1'b1; vs = 1'b1; x = '0; y = '0;
    clear_spr();

    // Reset with random inputs
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      hs = 1'($urandom); vs = 1'($urandom);
      x = 10'($urandom); y = 10'($urandom);
      spr_en = 4'($urandom);
      spr_x = {$urandom, $urandom}; spr_y = {$urandom, $urandom};
      spr_w = {$urandom, $urandom}; spr_h = {$urandom, $urandom};
      spr_col = {$urandom, $urandom};
    end
    chk("reset colour pri", {p_r, p_g, p_b}, 9'o000);
    chk("reset colour or", {o_r, o_g, o_b}, 9'o000);
    chk("reset syncs", {p_hs, p_vs, o_hs, o_vs}, 4'b1111);
    chk("reset collide", {p_col, o_col}, 8'h00);
    chk("reset frame", {p_fr, o_fr}, 2'b00);

    rst_n = 1'b1; hs = 1'b1; vs = 1'b1;
    clear_spr();
    set_spr(0, 1'b1, 10'd10, 10'd100, 10'd10, 10'd80, 9'o707);
    apply(0);

    frame_edge(4'b0000);
    apply(1);

    // Exact two-cycle latency of a single-cycle pixel
    x = 10'd700; y = 10'd100;
    repeat (3) @(posedge clk);
    #1;
    x = 10'd10;
    @(posedge clk);
    #1;
    chk("latency c1", {p_r, p_g, p_b}, 9'o000);
    x = 10'd700;
    @(posedge clk);
    #1;
    chk("latency c2", {p_r, p_g, p_b}, 9'o707);
    @(posedge clk);
    #1;
    chk("latency c3", {p_r, p_g, p_b}, 9'o000);

    clear_spr();
    set_spr(0, 1'b1, 10'd300, 10'd200, 10'd40, 10'd40, 9'o700);
    set_spr(1, 1'b1, 10'd300, 10'd200, 10'd40, 10'd40, 9'o007);
    frame_edge(4'b0000);
    apply(2);

    clear_spr();
    set_spr(1, 1'b1, 10'd100, 10'd50,  10'd5, 10'd5, 9'o070);
    set_spr(2, 1'b1, 10'd104, 10'd54,  10'd5, 10'd5, 9'o007);
    set_spr(3, 1'b1, 10'd400, 10'd300, 10'd2, 10'd2, 9'o770);
    frame_edge(4'b0011);
    apply(3);

    set_spr(2, 1'b1, 10'd200, 10'd54, 10'd5, 10'd5, 9'o007);
    frame_edge(4'b0110);
    apply(4);

    clear_spr();
    set_spr(0, 1'b1, 10'd10, 10'd100, 10'd10, 10'd80, 9'o707);
    frame_edge(4'b0000);
    spr_x[9:0] = 10'd200;
    apply(5);
    frame_edge(4'b0000);
    apply(6);

    clear_spr();
    set_spr(0, 1'b1, 10'd630,  10'd0, 10'd20, 10'd10, 9'o707);
    set_spr(1, 1'b1, 10'd1020, 10'd0, 10'd10, 10'd10, 9'o070);
    frame_edge(4'b0000);
    apply(7);

    // Random sync sequence, outputs must equal inputs two cycles earlier
    x = 10'd700; y = 10'd500;
    for (int i = 0; i < 40; i++) begin
      hs = 1'($urandom);
      vs = 1'($urandom);
      h_hist.push_back(hs);
      v_hist.push_back(vs);
      @(posedge clk);
      #1;
      if (i >= 1) begin
        chk($sformatf("hsync step %0d", i), {p_hs, o_hs}, {2{h_hist[i-1]}});
        chk($sformatf("vsync step %0d", i), {p_vs, o_vs}, {2{v_hist[i-1]}});
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_sprite_mixer.md
# vga_sprite_mixer

Parametrised N-channel sprite compositor for the 640x480 VGA path. It sits between the sync/position generator and the VGA pins, and replaces the per-object rectangle instances and the hand-written OR of their colours. Each frame it snapshots the geometry and colour of every sprite at vertical sync, and selects each pixel's colour by fixed priority or by OR-mixing. It delays HSync/VSync to stay aligned with the colour, and reports per-sprite overlap (collision) flags once per frame so the game engine can use them.

## Interface
- NUM_SPRITES, 4, number of sprite channels (1..8); index 0 has highest priority
- COORD_W, 10, width of the coordinate, size and position buses
- COLOR_W, 3, bits per colour component
- MIX_MODE, 1, 0 = bitwise OR of all hit colours, 1 = lowest-index hit wins
- H_ACTIVE, 640, visible width in pixels
- V_ACTIVE, 480, visible height in lines
- BG_COLOR, 0, 3*COLOR_W-bit background colour {R,G,B} for visible pixels with no hit
- i_CLK  in  1  pixel clock; the only clock
- i_RST_n  in  1  reset, synchronous, active-low
- i_hSync  in  1  horizontal sync, active-low
- i_vSync  in  1  vertical sync, active-low
- i_x_pos  in  COORD_W  current pixel column
- i_y_pos  in  COORD_W  current pixel row
- i_spr_en  in  NUM_SPRITES  per-sprite enable
- i_spr_x, i_spr_y  in  NUM_SPRITES*COORD_W  top-left corner of each sprite; sprite k occupies slice [k*COORD_W +: COORD_W]
- i_spr_w, i_spr_h  in  NUM_SPRITES*COORD_W  sprite width and height, packed the same way
- i_spr_color  in  NUM_SPRITES*3*COLOR_W  sprite colour {R,G,B}
- o_red, o_green, o_blue  out  COLOR_W each  mixed pixel colour
- o_hSync, o_vSync  out  1 each  syncs delayed to match the colour
- o_collide  out  NUM_SPRITES  bit k is 1 if sprite k overlapped any other enabled sprite on at least one visible pixel of the previous frame
- o_frame  out  1  one-cycle pulse when o_collide updates

## Operation
- Frame edge: the cycle where i_vSync is 0 and the registered previous i_vSync is 1.
- On the frame edge:
  - copy all i_spr_* inputs into shadow registers;
  - copy the collision accumulator to o_collide, then clear the accumulator;
  - pulse o_frame.
- Outside the frame edge, shadow registers hold their value, so mid-frame input changes never tear the image.
- Hit test for sprite k: shadow enable is set, and x >= sx and x < sx+w, and y >= sy and y < sy+h.
  - Compute the sums in COORD_W+1 bits, so sx+w never wraps.
  - w = 0 or h = 0 never hits.
- Visible pixel: i_x_pos < H_ACTIVE and i_y_pos < V_ACTIVE. Outside the visible area the colour output is 0 regardless of hits or BG_COLOR.
- Mix, MIX_MODE=1: colour of the lowest-index hit sprite; BG_COLOR if there is no hit.
- Mix, MIX_MODE=0: bitwise OR of all hit colours; BG_COLOR if there is no hit.
- Collision accumulation: on a visible pixel with two or more hits, OR the hit vector into the accumulator.
  - A frame edge and a visible hit cannot occur together.
  - If they ever do, the clear on the frame edge takes precedence.
- Reset (i_RST_n=0 at a clock edge), including mid-frame:
  - colour outputs 0;
  - o_hSync and o_vSync 1, along with both sync pipeline stages and the previous-vSync register;
  - o_collide 0, accumulator 0, o_frame 0;
  - shadow enables 0 (all sprites off until the first frame edge after reset).

## Timing
- Pipeline stage 1 registers: the hit vector, the visible flag, the syncs, and the accumulator update.
- Stage 2 registers: the mixed colour and the syncs.
- Latency from i_x_pos/i_y_pos/i_*Sync to o_red/o_green/o_blue/o_*Sync is exactly 2 cycles.
- Syncs and colour stay aligned in every cycle.
- o_collide and o_frame change 1 cycle after the clock edge on which the frame edge is sampled; o_frame is high for exactly 1 cycle.
- New shadow values first affect the pixel stream at the first stage-1 evaluation after the frame edge.
- Throughput is one pixel per clock with no stalls.

## Structure
- A shared package, vga_pkg, holds:
  - the H_ACTIVE/V_ACTIVE defaults;
  - the colour width constant;
  - a function, or matching localparams, for slice offsets of the packed per-sprite buses.
- One sub-module: vga_sprite_hit, a combinational hit test per sprite (position, size and enable in, hit out), instantiated NUM_SPRITES times with a generate loop.
- The top-level pin ORing is replaced by this block.

## Test plan
- Reset: hold i_RST_n=0 for 3 cycles with random inputs -> colour outputs 0, syncs 1, o_collide=0, o_frame=0; no sprite is drawn before the first frame edge.
- Single sprite, MIX_MODE=1:
  - setup: sprite 0 at (10,100), 10x80, colour 9'o707, enabled;
  - at pixel (10,100) -> colour 7/0/7 two cycles later;
  - at (20,100) and (10,180) -> BG_COLOR.
- Priority overlap:
  - setup: sprite 0 colour 7/0/0 and sprite 1 colour 0/0/7, both at (300,200) size 40x40;
  - MIX_MODE=1 -> 7/0/0;
  - MIX_MODE=0 -> 7/0/7.
- Collision:
  - frame N: sprites 1 and 2 overlap at one pixel and sprite 3 is isolated;
  - next frame edge -> o_collide=4'b0110 and o_frame high for 1 cycle;
  - frame N+1 with no overlap -> following edge gives o_collide=0.
- Shadowing and bounds:
  - change i_spr_x mid-frame -> the image is unchanged until the next frame edge;
  - a sprite at x=630, w=20 -> drawn on columns 630..639, nothing at x >= 640, no wrap to column 0;
  - i_spr_x=1020 with w=10 -> never hits.
- Alignment: apply a random i_hSync/i_vSync sequence -> o_hSync/o_vSync equal the inputs delayed by exactly 2 cycles.
